lcd_bus_receiver: RTL and testbench

- Sink end of the parallel RGB LCD bus driven by lcdPixelWriter: the 24-bit rgb, hsync, vsync, d_en and disp_en pins.
- Recovers the pixel stream with x/y coordinates, frame/line markers and a frame counter.
- Flags timing errors as sticky bits.
- Used in unit tests and loopback: FPGA output pins feed back into it. Also usable as a capture front-end for a frame checker.

---
 rtl/lcd_rx_pkg.sv | 20 ++
 rtl/lcd_sync_edge.sv | 32 +++
 rtl/lcd_bus_receiver.sv | 261 ++++++++++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the LCD bus receiver.
package lcd_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBLANK = 2'd1,
        LINE   = 2'd2,
        HBLANK = 2'd3
    } lcd_rx_state_t;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/lcd_sync_edge.sv
// Registers one bus control pin, normalises it to active-high and flags its edges.
module lcd_sync_edge #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic assert_o,
    output logic deassert_o
);

    logic level_q, level_d;
    logic prev_q;

    assign level_d = pin_i ^ ACTIVE_LOW;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    assign level_o    = level_q;
    assign assert_o   = level_q & ~prev_q;
    assign deassert_o = ~level_q & prev_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Parallel RGB LCD bus sink: recovers pixels with x/y, line/frame markers and sticky timing errors.
// Define LCD_RX_CHECKSUM_EN to add the per-frame pixel checksum output frame_sum.
module lcd_bus_receiver
    import lcd_rx_pkg::*;
#(
    parameter int H_ACTIVE        = 480,
    parameter int V_ACTIVE        = 272,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int XW              = 10,
    parameter int YW              = 9
) (
    input  logic                   clk_12mhz,
    input  logic                   rst,
    input  logic [23:0]            rgb,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   d_en,
    input  logic                   disp_en,
    input  logic                   err_clr,
    output logic                   pix_valid,
    output logic [23:0]            pix_rgb,
    output logic [XW-1:0]          pix_x,
    output logic [YW-1:0]          pix_y,
    output logic                   line_end,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_hlen,
    output logic                   err_vlen,
    output logic                   err_de_sync
`ifdef LCD_RX_CHECKSUM_EN
   ,output logic [31:0]            frame_sum
`endif
);

    // x/y carry one extra bit so they can hold H_ACTIVE / V_ACTIVE themselves.
    localparam logic [XW:0] X_END = (XW+1)'(H_ACTIVE);
    localparam logic [YW:0] Y_END = (YW+1)'(V_ACTIVE);
    localparam bit SYNC_LOW = (SYNC_ACTIVE_LOW != 0);

    logic hs_lvl, hs_rise, hs_fall;
    logic vs_lvl, vs_rise, vs_fall;
    logic de_lvl, de_rise, de_fall;
    logic unused_edges;

    lcd_sync_edge #(.ACTIVE_LOW(SYNC_LOW)) u_hs (
        .clk_i(clk_12mhz), .rst_i(rst), .pin_i(hsync),
        .level_o(hs_lvl), .assert_o(hs_rise), .deassert_o(hs_fall)
    );
    lcd_sync_edge #(.ACTIVE_LOW(SYNC_LOW)) u_vs (
        .clk_i(clk_12mhz), .rst_i(rst), .pin_i(vsync),
        .level_o(vs_lvl), .assert_o(vs_rise), .deassert_o(vs_fall)
    );
    lcd_sync_edge #(.ACTIVE_LOW(1'b0)) u_de (
        .clk_i(clk_12mhz), .rst_i(rst), .pin_i(d_en),
        .level_o(de_lvl), .assert_o(de_rise), .deassert_o(de_fall)
    );

    assign unused_edges = hs_rise ^ hs_fall ^ vs_fall;

    logic [23:0]            rgb_q;
    logic                   disp_en_q, err_clr_q;
    lcd_rx_state_t          state_q, state_d;
    logic [XW:0]            x_q, x_d;
    logic [YW:0]            y_q, y_d;
    logic                   bad_q, bad_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [23:0]            pix_rgb_q, pix_rgb_d;
    logic [XW-1:0]          pix_x_q, pix_x_d;
    logic [YW-1:0]          pix_y_q, pix_y_d;
    logic                   line_end_q, line_end_d;
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   err_hlen_q, err_hlen_d;
    logic                   err_vlen_q, err_vlen_d;
    logic                   err_de_sync_q, err_de_sync_d;
    logic                   capture;

    // IDLE: waiting for vs edge | VBLANK: before first line | LINE: d_en run | HBLANK: between lines
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        bad_d         = bad_q;
        pix_valid_d   = 1'b0;
        pix_rgb_d     = pix_rgb_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        line_end_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_hlen_d    = err_hlen_q & ~err_clr_q;
        err_vlen_d    = err_vlen_q & ~err_clr_q;
        err_de_sync_d = err_de_sync_q & ~err_clr_q;
        capture       = 1'b0;

        if (de_lvl && (hs_lvl || vs_lvl)) begin
            err_de_sync_d = 1'b1;
        end

        if (!disp_en_q) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            bad_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vs_rise) begin
                        state_d = VBLANK;
                        x_d     = '0;
                        y_d     = '0;
                        bad_d   = 1'b0;
                    end
                end
                VBLANK: begin
                    if (de_rise) begin
                        state_d = LINE;
                        capture = 1'b1;
                    end
                end
                HBLANK: begin
                    if (de_rise) begin
                        if (y_q == Y_END) begin
                            err_vlen_d = 1'b1;
                        end else begin
                            state_d = LINE;
                            capture = 1'b1;
                        end
                    end
                end
                LINE: begin
                    capture = de_lvl;
                    if (de_fall) begin
                        line_end_d = 1'b1;
                        if (x_q != X_END) begin
                            err_hlen_d = 1'b1;
                            bad_d      = 1'b1;
                        end
                        x_d = '0;
                        if (y_q != Y_END) begin
                            y_d = y_q + 1'b1;
                        end
                        state_d = HBLANK;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (capture) begin
                if (x_q != X_END) begin
                    pix_valid_d = 1'b1;
                    pix_rgb_d   = {rgb_q[R_HI:R_LO], rgb_q[G_HI:G_LO], rgb_q[B_HI:B_LO]};
                    pix_x_d     = x_q[XW-1:0];
                    pix_y_d     = y_q[YW-1:0];
                    x_d         = x_q + 1'b1;
                end else begin
                    err_hlen_d = 1'b1;
                    bad_d      = 1'b1;
                end
            end

            // Frame close sees the line count after any coincident line_end.
            if (vs_rise && state_q != IDLE) begin
                if (y_d == Y_END && !bad_d) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                end
                if (y_d != '0 && y_d != Y_END) begin
                    err_vlen_d = 1'b1;
                end
                x_d     = '0;
                y_d     = '0;
                bad_d   = 1'b0;
                state_d = VBLANK;
            end
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            rgb_q         <= '0;
            disp_en_q     <= 1'b0;
            err_clr_q     <= 1'b0;
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            bad_q         <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_rgb_q     <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_end_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            err_hlen_q    <= 1'b0;
            err_vlen_q    <= 1'b0;
            err_de_sync_q <= 1'b0;
        end else begin
            rgb_q         <= rgb;
            disp_en_q     <= disp_en;
            err_clr_q     <= err_clr;
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            bad_q         <= bad_d;
            pix_valid_q   <= pix_valid_d;
            pix_rgb_q     <= pix_rgb_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_end_q    <= line_end_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            err_hlen_q    <= err_hlen_d;
            err_vlen_q    <= err_vlen_d;
            err_de_sync_q <= err_de_sync_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_rgb     = pix_rgb_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign line_end    = line_end_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_hlen    = err_hlen_q;
    assign err_vlen    = err_vlen_q;
    assign err_de_sync = err_de_sync_q;

`ifdef LCD_RX_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] frame_sum_q, frame_sum_d;

    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        if (pix_valid_d) begin
            acc_d = acc_q + {8'h00, rgb_q};
        end
        if (frame_done_d) begin
            frame_sum_d = acc_d;
        end
        if (vs_rise) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            acc_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver on an 8x4 raster with active-low syncs.
module tb_lcd_bus_receiver;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk_12mhz = 1'b0;
    logic        rst;
    logic [23:0] rgb;
    logic        hsync, vsync, d_en, disp_en, err_clr;
    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic [3:0]  pix_x;
    logic [2:0]  pix_y;
    logic        line_end, frame_done;
    logic [15:0] frame_cnt;
    logic        err_hlen, err_vlen, err_de_sync;
`ifdef LCD_RX_CHECKSUM_EN
    logic [31:0] frame_sum;
`endif

    int errors = 0;
    int checks = 0;
    bit white  = 1'b0;

    always #5 clk_12mhz = ~clk_12mhz;

    lcd_bus_receiver #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1), .XW(4), .YW(3)
    ) dut (
        .clk_12mhz(clk_12mhz), .rst(rst), .rgb(rgb), .hsync(hsync), .vsync(vsync),
        .d_en(d_en), .disp_en(disp_en), .err_clr(err_clr),
        .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y),
        .line_end(line_end), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .err_hlen(err_hlen), .err_vlen(err_vlen), .err_de_sync(err_de_sync)
`ifdef LCD_RX_CHECKSUM_EN
       ,.frame_sum(frame_sum)
`endif
    );

    task automatic tick();
        @(posedge clk_12mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pat(input int xx, input int yy);
        if (white) return 24'hFFFFFF;
        return {8'h00, 8'(yy), 8'(xx)};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, ".pix_rgb"}, 32'(pix_rgb), 32'd0);
        chk({tag, ".pix_x"}, 32'(pix_x), 32'd0);
        chk({tag, ".pix_y"}, 32'(pix_y), 32'd0);
        chk({tag, ".line_end"}, 32'(line_end), 32'd0);
        chk({tag, ".frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, ".err_hlen"}, 32'(err_hlen), 32'd0);
        chk({tag, ".err_vlen"}, 32'(err_vlen), 32'd0);
        chk({tag, ".err_de_sync"}, 32'(err_de_sync), 32'd0);
`ifdef LCD_RX_CHECKSUM_EN
        chk({tag, ".frame_sum"}, frame_sum, 32'd0);
`endif
    endtask

    task automatic chk_errs(input string tag, input bit h, input bit v, input bit s);
        chk({tag, ".err_hlen"}, 32'(err_hlen), 32'(h));
        chk({tag, ".err_vlen"}, 32'(err_vlen), 32'(v));
        chk({tag, ".err_de_sync"}, 32'(err_de_sync), 32'(s));
    endtask

    // Outputs trail the bus by one edge, so pixel i is checked after driving pixel i+1.
    task automatic line(input int n, input int yy, input bit cap);
        bit vld;
        for (int i = 0; i <= n + 1; i++) begin
            d_en = (i < n);
            rgb  = (i < n) ? pat(i, yy) : 24'h0;
            tick();
            if (i >= 1 && i <= n) begin
                vld = cap && (i - 1 < H);
                chk("pix_valid", 32'(pix_valid), 32'(vld));
                if (vld) begin
                    chk("pix_x", 32'(pix_x), 32'(i - 1));
                    chk("pix_y", 32'(pix_y), 32'(yy));
                    chk("pix_rgb", 32'(pix_rgb), 32'(pat(i - 1, yy)));
                end
            end
            if (i == n + 1) chk("line_end", 32'(line_end), 32'(cap));
        end
    endtask

    task automatic frame(input int nl);
        for (int yy = 0; yy < nl; yy++) line(H, yy, 1'b1);
    endtask

    task automatic vs_pulse(input bit fd, input int cnt);
        d_en  = 1'b0;
        vsync = 1'b0;
        tick();
        tick();
        chk("frame_done", 32'(frame_done), 32'(fd));
        chk("frame_cnt", 32'(frame_cnt), 32'(cnt));
        vsync = 1'b1;
        tick();
        chk("frame_done_single", 32'(frame_done), 32'd0);
        tick();
        tick();
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        chk_errs("clr", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rgb = '0; hsync = 1'b1; vsync = 1'b1;
        d_en = 1'b0; disp_en = 1'b0; err_clr = 1'b0;
        tick(); tick(); tick();
        chk_zero("reset");
        rst = 1'b0;
        disp_en = 1'b1;
        tick(); tick();

        // No capture before the first vs edge.
        line(H, 0, 1'b0);

        // Three clean frames.
        vs_pulse(1'b0, 0);
        for (int f = 0; f < 3; f++) begin
            frame(V);
            vs_pulse(1'b1, f + 1);
        end
        chk_errs("clean", 1'b0, 1'b0, 1'b0);

        // Short line 2 spoils the frame; the next clean frame still counts.
        line(H, 0, 1'b1);
        line(H, 1, 1'b1);
        line(7, 2, 1'b1);
        chk("hlen_short", 32'(err_hlen), 32'd1);
        line(H, 3, 1'b1);
        vs_pulse(1'b0, 3);
        frame(V);
        vs_pulse(1'b1, 4);
        chk("hlen_vlen_clean", 32'(err_vlen), 32'd0);
        clr_pulse();

        // Fifth line is dropped and flags err_vlen; reset mid-frame after it.
        frame(V);
        line(H, 4, 1'b0);
        chk("vlen_long", 32'(err_vlen), 32'd1);
        rst = 1'b1;
        tick();
        chk_zero("rst_mid");
        rst = 1'b0;
        tick();

        // Three-line frame.
        vs_pulse(1'b0, 0);
        frame(3);
        vs_pulse(1'b0, 0);
        chk("vlen_short", 32'(err_vlen), 32'd1);
        clr_pulse();

        // disp_en dropped during line 1.
        line(H, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            disp_en = (i < 3);
            d_en    = 1'b1;
            rgb     = pat(i, 1);
            tick();
            if (i == 3) begin
                chk("drop_last_valid", 32'(pix_valid), 32'd1);
                chk("drop_last_x", 32'(pix_x), 32'd2);
            end
            if (i == 4) chk("drop_valid_off", 32'(pix_valid), 32'd0);
        end
        d_en = 1'b0;
        tick(); tick(); tick();
        chk_errs("drop", 1'b0, 1'b0, 1'b0);
        disp_en = 1'b1;
        tick();
        line(H, 0, 1'b0);
        vs_pulse(1'b0, 0);
        frame(V);
        vs_pulse(1'b1, 1);
        chk_errs("after_drop", 1'b0, 1'b0, 1'b0);

        // d_en during asserted vsync.
        d_en = 1'b1; vsync = 1'b0;
        tick();
        d_en = 1'b0; vsync = 1'b1;
        tick();
        chk("de_sync_vs", 32'(err_de_sync), 32'd1);
        chk("de_sync_cnt", 32'(frame_cnt), 32'd1);
        tick();

        // err_clr coincident with a new de_sync error: set wins.
        err_clr = 1'b1; d_en = 1'b1; hsync = 1'b0;
        tick();
        err_clr = 1'b0; d_en = 1'b0; hsync = 1'b1;
        tick();
        chk("clr_vs_set", 32'(err_de_sync), 32'd1);
        tick(); tick();
        clr_pulse();

`ifdef LCD_RX_CHECKSUM_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        white = 1'b1;
        vs_pulse(1'b0, 0);
        frame(V);
        vs_pulse(1'b1, 1);
        chk("frame_sum", frame_sum, 32'h1FFFFFE0);
        white = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
